// File: rtl/approx_mult_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : approx_mult_engine
// Brief    : Normalises operand pairs, keeps KEEP_W MSBs of each and writes {shift_sum, product}.
//            Optional rounding of kept bits: define APPROX_MULT_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mult_engine #(
  parameter  int DATA_W  = 16,
  parameter  int KEEP_W  = 8,
  parameter  int N_PAIRS = 8,
  localparam int IN_AW   = $clog2(2*N_PAIRS),
  localparam int OUT_AW  = $clog2(N_PAIRS),
  localparam int SHW     = $clog2(2*DATA_W+1),
  localparam int RES_W   = SHW + 2*KEEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic [RES_W-1:0]  out_wdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_NORM_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_NORM_B = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int                c_PW        = 2*KEEP_W;
  localparam logic [SHW-1:0]    c_SH_MAX    = SHW'(DATA_W);
  localparam logic [OUT_AW-1:0] c_LAST_PAIR = OUT_AW'(N_PAIRS-1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OUT_AW-1:0]   r_pair;
  logic [IN_AW-1:0]    r_in_addr;
  logic [DATA_W-1:0]   r_sreg;
  logic [SHW-1:0]      r_sh_a;
  logic [SHW-1:0]      r_sh_b;
  logic [KEEP_W-1:0]   r_keep_a;
  logic [KEEP_W-1:0]   r_keep_b;

  logic [SHW-1:0]      w_sh_cur;
  logic                w_norm_exit;
  logic [KEEP_W-1:0]   w_keep_trunc;
  logic [KEEP_W-1:0]   w_keep;
  logic [OUT_AW-1:0]   w_pair_inc;
  logic [c_PW-1:0]     w_prod;
  logic [SHW-1:0]      w_sh_sum;

  // A zero operand never reaches a set MSB, so the count limit ends normalisation.
  assign w_sh_cur     = (r_state == S_NORM_B) ? r_sh_b : r_sh_a;
  assign w_norm_exit  = r_sreg[DATA_W-1] || (w_sh_cur == c_SH_MAX);
  assign w_keep_trunc = r_sreg[DATA_W-1 -: KEEP_W];
  assign w_pair_inc   = r_pair + OUT_AW'(1);
  assign w_prod       = c_PW'(r_keep_a) * c_PW'(r_keep_b);
  assign w_sh_sum     = r_sh_a + r_sh_b;
  assign in_addr      = r_in_addr;

`ifdef APPROX_MULT_ROUND_EN
  generate
    if (KEEP_W < DATA_W) begin : g_round
      logic [KEEP_W:0] w_rsum;
      assign w_rsum = {1'b0, w_keep_trunc} + (KEEP_W+1)'(r_sreg[DATA_W-1-KEEP_W]);
      assign w_keep = w_rsum[KEEP_W] ? {KEEP_W{1'b1}} : w_rsum[KEEP_W-1:0];
    end else begin : g_no_round
      assign w_keep = w_keep_trunc;
    end
  endgenerate
`else
  assign w_keep = w_keep_trunc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    out_we      = 1'b0;
    out_addr    = '0;
    out_wdata   = '0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD_A;
      S_LOAD_A: begin busy = 1'b1; w_state_nxt = S_NORM_A; end
      S_NORM_A: begin busy = 1'b1; if (w_norm_exit) w_state_nxt = S_LOAD_B; end
      S_LOAD_B: begin busy = 1'b1; w_state_nxt = S_NORM_B; end
      S_NORM_B: begin busy = 1'b1; if (w_norm_exit) w_state_nxt = S_WRITE; end
      S_WRITE: begin
        busy        = 1'b1;
        out_we      = 1'b1;
        out_addr    = r_pair;
        out_wdata   = {w_sh_sum, w_prod};
        w_state_nxt = (r_pair == c_LAST_PAIR) ? S_DONE : S_LOAD_A;
      end
      S_DONE:   begin done = 1'b1; w_state_nxt = S_IDLE; end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The read address is set on the transition into each LOAD state and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pair    <= '0;
      r_in_addr <= '0;
      r_sreg    <= '0;
      r_sh_a    <= '0;
      r_sh_b    <= '0;
      r_keep_a  <= '0;
      r_keep_b  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pair    <= '0;
            r_in_addr <= '0;
          end
        end
        S_LOAD_A: begin
          r_sreg <= in_rdata;
          r_sh_a <= '0;
        end
        S_NORM_A: begin
          if (w_norm_exit) begin
            r_keep_a  <= w_keep;
            r_in_addr <= IN_AW'({r_pair, 1'b1});
          end else begin
            r_sreg <= r_sreg << 1;
            r_sh_a <= r_sh_a + SHW'(1);
          end
        end
        S_LOAD_B: begin
          r_sreg <= in_rdata;
          r_sh_b <= '0;
        end
        S_NORM_B: begin
          if (w_norm_exit) begin
            r_keep_b <= w_keep;
          end else begin
            r_sreg <= r_sreg << 1;
            r_sh_b <= r_sh_b + SHW'(1);
          end
        end
        S_WRITE: begin
          if (r_pair != c_LAST_PAIR) begin
            r_pair    <= w_pair_inc;
            r_in_addr <= IN_AW'({w_pair_inc, 1'b0});
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_approx_mult_engine
// Brief    : Directed scoreboard bench for approx_mult_engine (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mult_engine;

  localparam int DATA_W  = 16;
  localparam int KEEP_W  = 8;
  localparam int N_PAIRS = 8;
  localparam int IN_AW   = 4;
  localparam int OUT_AW  = 3;
  localparam int RES_W   = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [IN_AW-1:0]  in_addr;
  logic [DATA_W-1:0] in_rdata;
  logic              out_we;
  logic [OUT_AW-1:0] out_addr;
  logic [RES_W-1:0]  out_wdata;

  logic [15:0] mem [0:15];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [OUT_AW-1:0] exp_addr_q [$];
  logic [RES_W-1:0]  exp_data_q [$];
  int                wr_cyc [$];
  int                wr_cnt   = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                unexp    = 0;

  logic [RES_W-1:0] exp_res [N_PAIRS];
  int               exp_lat [N_PAIRS];
  int               c0, wr_base, done_base, wr_hold;

  approx_mult_engine #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .N_PAIRS(N_PAIRS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_addr   (in_addr),
    .in_rdata  (in_rdata),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .out_wdata (out_wdata)
  );

  always #5 clk = ~clk;
  assign in_rdata = mem[in_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nshift(input logic [15:0] x);
    int s;
    logic [15:0] v;
    s = 0;
    v = x;
    while (s < 16 && v[15] == 1'b0) begin
      v = v << 1;
      s++;
    end
    return s;
  endfunction

  function automatic logic [7:0] nkeep(input logic [15:0] x);
    logic [15:0] v;
    logic [8:0]  r;
    v = x << nshift(x);
    r = {1'b0, v[15:8]};
`ifdef APPROX_MULT_ROUND_EN
    if (v[7]) r = r + 9'd1;
    if (r[8]) r = 9'h0FF;
`endif
    return r[7:0];
  endfunction

  function automatic logic [RES_W-1:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    logic [5:0]  s;
    p = {8'd0, nkeep(a)} * {8'd0, nkeep(b)};
    s = 6'(nshift(a) + nshift(b));
    return {s, p};
  endfunction

  task automatic model_all();
    for (int p = 0; p < N_PAIRS; p++) begin
      exp_res[p] = model(mem[2*p], mem[2*p+1]);
      exp_lat[p] = nshift(mem[2*p]) + nshift(mem[2*p+1]) + 5;
    end
  endtask

  task automatic fill_random(input int first);
    logic [15:0] t;
    for (int i = first; i < 2*N_PAIRS; i++) begin
      t = 16'($urandom_range(0, 65535));
      mem[i] = t >> $urandom_range(0, 15);
    end
  endtask

  // Write monitor: scoreboard pop on every write, done pulse bookkeeping.
  always @(negedge clk) begin
    if (out_we === 1'b1) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      if (exp_data_q.size() == 0) begin
        unexp++;
      end else begin
        chk("wr_addr", 32'(out_addr), 32'(exp_addr_q.pop_front()));
        chk("wr_data", 32'(out_wdata), 32'(exp_data_q.pop_front()));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic launch();
    for (int p = 0; p < N_PAIRS; p++) begin
      exp_addr_q.push_back(OUT_AW'(p));
      exp_data_q.push_back(exp_res[p]);
    end
    wr_cyc.delete();
    wr_base   = wr_cnt;
    done_base = done_cnt;
    unexp     = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done_and_check(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse_len"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
    chk({tag, "_write_count"}, 32'(wr_cnt - wr_base), 32'(N_PAIRS));
    chk({tag, "_sb_empty"}, 32'(exp_data_q.size()), 32'd0);
    chk({tag, "_unexpected"}, 32'(unexp), 32'd0);
    if (wr_cyc.size() == N_PAIRS) begin
      chk({tag, "_lat0"}, 32'(wr_cyc[0] - c0 + 1), 32'(exp_lat[0]));
      for (int p = 1; p < N_PAIRS; p++)
        chk($sformatf("%s_lat%0d", tag, p), 32'(wr_cyc[p] - wr_cyc[p-1]), 32'(exp_lat[p]));
      chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(wr_cyc[N_PAIRS-1] + 1));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_out_we"}, 32'(out_we), 32'd0);
    chk({tag, "_in_addr"}, 32'(in_addr), 32'd0);
    chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    chk({tag, "_out_wdata"}, 32'(out_wdata), 32'd0);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Run 1: directed corner pairs plus random ones; extra start while busy.
    mem[0]  = 16'h8000; mem[1]  = 16'h8000;
    mem[2]  = 16'h0003; mem[3]  = 16'h0100;
    mem[4]  = 16'h0000; mem[5]  = 16'h1234;
    mem[6]  = 16'h0181; mem[7]  = 16'h8000;
    mem[8]  = 16'h0000; mem[9]  = 16'h0000;
    mem[10] = 16'hFFFF; mem[11] = 16'h0001;
    fill_random(12);
    model_all();
    exp_res[0] = {6'd0, 16'h4000};  exp_lat[0] = 5;
    exp_res[1] = {6'd21, 16'h6000}; exp_lat[1] = 26;
    exp_res[2] = {6'd19, 16'h0000}; exp_lat[2] = 24;
`ifdef APPROX_MULT_ROUND_EN
    exp_res[3] = {6'd7, 16'h6080};
`else
    exp_res[3] = {6'd7, 16'h6000};
`endif
    exp_lat[3] = 12;
    exp_res[4] = {6'd32, 16'h0000}; exp_lat[4] = 37;
    launch();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done_and_check("run1");
    repeat (3) @(negedge clk);
    chk("run1_no_restart", 32'(busy), 32'd0);

    // Run 2: reset during NORM_B of pair 3, then reset coinciding with start.
    fill_random(0);
    mem[6] = 16'h8000;
    mem[7] = 16'h0001;
    model_all();
    launch();
    n = 0;
    while ((wr_cnt - wr_base) < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("run2_three_writes", 32'(wr_cnt - wr_base), 32'd3);
    repeat (5) @(negedge clk);
    chk("run2_busy_in_norm_b", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    wr_hold = wr_cnt;
    @(negedge clk);
    chk_reset_outputs("midrun_reset");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("start_with_rst", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("no_write_after_reset", 32'(wr_cnt), 32'(wr_hold));
    chk("no_unexpected_after_reset", 32'(unexp), 32'd0);

    // Run 3: fresh start after reset must write from address 0.
    fill_random(0);
    mem[0] = 16'h0000;
    mem[15] = 16'h0000;
    model_all();
    launch();
    wait_done_and_check("run3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/approx_mult_engine.md
Name: approx_mult_engine

Overview:
- Parametrised successor of the leading-one truncation multiplier datapath, with its own controller FSM.
- Reads N_PAIRS operand pairs from an external input memory and normalises each operand by left-shifting until its MSB is 1. It keeps the top KEEP_W bits of each operand and multiplies them.
- Writes {shift_sum, product} per pair to an external output memory.
- Sits between the operand ROM/RAM and the result RAM; started by a start pulse, reports completion with a done pulse.

Parameters:
- DATA_W, 16, operand width in input memory.
- KEEP_W, 8, bits kept per operand after normalisation (KEEP_W <= DATA_W).
- N_PAIRS, 8, operand pairs per run (>= 2). Input memory holds 2*N_PAIRS words: A at even address, B at odd address.
- Derived, not overridable:
  - IN_AW = $clog2(2*N_PAIRS)
  - OUT_AW = $clog2(N_PAIRS)
  - SHW = $clog2(2*DATA_W+1)
  - RES_W = SHW + 2*KEEP_W

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse after the last write.
- in_addr  output  IN_AW  input memory address; combinational read.
- in_rdata  input  DATA_W  input memory data, valid in the same cycle as in_addr.
- out_we  output  1  output memory write enable.
- out_addr  output  OUT_AW  output memory address (pair index).
- out_wdata  output  RES_W  {shift_sum[SHW-1:0], product[2*KEEP_W-1:0]}.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, out_we=0; in_addr=0, out_addr=0, out_wdata=0. Pair index, shift counters, operand and kept registers all cleared.
- IDLE: start=1 -> LOAD_A with pair=0. start while not IDLE is ignored.
- LOAD_A (1 cycle):
  - in_addr = 2*pair.
  - Shift register loads in_rdata; sh_a cleared.
  - Next state NORM_A.
- NORM_A (one cycle per step):
  - If sreg[DATA_W-1]==1 or sh_a==DATA_W: keep_a = sreg[DATA_W-1 -: KEEP_W], go to LOAD_B.
  - Otherwise sreg <<= 1 (zero fill) and sh_a += 1.
  - Lasts sh_a+1 cycles.
- LOAD_B / NORM_B: identical to LOAD_A / NORM_A, with in_addr = 2*pair+1, sh_b and keep_b. Exit goes to WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr=pair.
  - out_wdata = {sh_a+sh_b, keep_a*keep_b}, with an unsigned full-width product.
  - If pair==N_PAIRS-1, go to DONE; else pair+=1 and go to LOAD_A.
- DONE (1 cycle): done=1, busy=0 in this cycle, then IDLE. out_we is 0 outside WRITE.
- Latency per pair: sh_a + sh_b + 5 cycles. Total run time is the sum over pairs plus 1 (DONE).
- Zero operand: normalisation stops at count DATA_W (DATA_W+1 cycles in NORM_x), keep=0, product=0. shift_sum still reports the true count sum, e.g. DATA_W + sh_other.
- MSB already set: 0 shifts, 1 NORM cycle.
- in_addr is held at the LOAD address during NORM states. Outside LOAD states it is don't-care for the memory but must be stable.
- Reset mid-run (any state): next cycle is IDLE with all outputs at reset values. No write issued after reset. The next start restarts from pair 0.
- start and rst in the same cycle: reset wins.

Optional Feature:
- Macro: APPROX_MULT_ROUND_EN.
- Defined: at capture, keep_x = top KEEP_W bits + sreg[DATA_W-1-KEEP_W] (round-half-up), saturating at all-ones. Applies only when KEEP_W < DATA_W; otherwise there is no effect.
- Undefined: plain truncation.
- Timing and every other behaviour are identical in both builds.

Test Plan:
- A=16'h8000, B=16'h8000 -> pair takes 5 cycles; out_wdata = {6'd0, 16'h4000}.
- A=16'h0003, B=16'h0100 -> shifts 14 and 7; keep C0/80; out_wdata = {6'd21, 16'h6000}; pair takes 26 cycles.
- A=16'h0000, B=16'h1234 -> NORM_A lasts 17 cycles; B normalised to 91A0; out_wdata = {6'd19, 16'h0000}.
- Full run, N_PAIRS=8, start re-pulsed while busy -> exactly 8 writes at out_addr 0..7 in order; single done pulse; extra start ignored.
- rst asserted during NORM_B of pair 3 -> next cycle busy=0, out_we=0, no write to addr 3. A new start writes from addr 0.
- APPROX_MULT_ROUND_EN defined, A=16'h0181, B=16'h8000 -> keep_a=C1; out_wdata = {6'd7, 16'h6080}. Undefined: {6'd7, 16'h6000}.
